// File: rtl/frame_buf_pkg.sv
// Shared constants, read-enable polarity and scan state encoding for the frame scanner.
// Imported by frame_scan and scan_skid.
package frame_buf_pkg;

   // Memory read enable is active-low
   localparam logic ASSERT   = 1'b0;
   localparam logic DEASSERT = 1'b1;

   localparam int unsigned DEF_DATA_WIDTH = 24;
   localparam int unsigned DEF_ADDR_WIDTH = 3;
   localparam int unsigned DEF_LINE_LEN   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } scan_state_t;

   // Counter width that stays legal for a one-pixel line
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_skid.sv
// Two-entry output buffer for the pixel stream; head entry drives the outputs.
// The writer never pushes into a full buffer unless the same edge pops.
module scan_skid
   import frame_buf_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_DATA_WIDTH + 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       level
);

   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   assign out_valid = (count != 2'd0);
   assign out_data  = head;
   assign level     = count;
   assign push      = in_valid;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head <= in_data;
               end else begin
                  tail <= in_data;
               end
               if (count != 2'd2) begin
                  count <= count + 2'd1;
               end
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Simultaneous push/pop keeps the level; order is preserved
               if (count == 2'd1) begin
                  head <= in_data;
               end else begin
                  head <= tail;
                  tail <= in_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/frame_scan.sv
// Frame scanner: reads a frame from memory and streams it as pixels with sof/eol.
// Define FRAME_SCAN_REPEAT_EN to rescan the frame continuously after the first start.
module frame_scan
   import frame_buf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned LINE_LEN   = DEF_LINE_LEN
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_rdy,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic [DATA_WIDTH-1:0] pix_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  pix_sof,
   output logic                  pix_eol,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned            LW        = cnt_width(LINE_LEN);
   localparam int unsigned            SW        = DATA_WIDTH + 2;
   localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = '1;
   localparam logic [LW-1:0]          LAST_COL  = LW'(LINE_LEN - 1);

   scan_state_t           state;
   scan_state_t           state_nxt;
   logic [ADDR_WIDTH-1:0] addr;
   logic [LW-1:0]         col;
   logic                  rd_pending;
   logic                  rd_sof;
   logic                  rd_eol;
   logic                  issue;
   logic                  has_slot;
   logic                  start;
   logic                  drained;
   logic                  pop;
   logic                  busy_r;
   logic                  done_r;
   logic [1:0]            level;
   logic [2:0]            slots_used;
   logic [SW-1:0]         skid_in;
   logic [SW-1:0]         skid_out;

`ifdef FRAME_SCAN_REPEAT_EN
   logic rescan;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rescan <= 1'b0;
      end else if (state == DRAIN && drained) begin
         rescan <= 1'b1;
      end
   end

   assign start = frame_rdy || rescan;
`else
   assign start = frame_rdy;
`endif

   assign pop        = pix_valid && pix_ready;
   assign slots_used = {1'b0, level} + {2'b00, rd_pending};
   // A slot freed by this cycle's pop may be refilled, giving one read per clk
   assign has_slot   = (slots_used < 3'd2) || (slots_used == 3'd2 && pop);
   assign drained    = pop && (level == 2'd1) && !rd_pending;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            issue = has_slot;
            if (has_slot && addr == LAST_ADDR) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (drained) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr       <= '0;
         col        <= '0;
         rd_pending <= 1'b0;
         rd_sof     <= 1'b0;
         rd_eol     <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         rd_pending <= issue;
         done_r     <= 1'b0;
         if (issue) begin
            rd_sof <= (addr == '0);
            rd_eol <= (col == LAST_COL);
            addr   <= addr + 1'b1;
            col    <= (col == LAST_COL) ? '0 : col + 1'b1;
         end
         if (state == IDLE && start) begin
            addr   <= '0;
            col    <= '0;
            busy_r <= 1'b1;
         end
         if (state == DRAIN && drained) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end
      end
   end

   assign skid_in = {rd_sof, rd_eol, mem_rd_data};

   scan_skid #(
      .WIDTH(SW)
   ) u_skid (
      .clk      (clk),
      .reset    (reset),
      .in_data  (skid_in),
      .in_valid (rd_pending),
      .out_data (skid_out),
      .out_valid(pix_valid),
      .out_ready(pix_ready),
      .level    (level)
   );

   assign {pix_sof, pix_eol, pix_data} = skid_out;
   assign mem_rd_en   = issue ? ASSERT : DEASSERT;
   assign mem_rd_addr = addr;
   assign busy        = busy_r;
   assign frame_done  = done_r;

endmodule

// File: tb/tb_frame_scan.sv
// Scoreboard bench for frame_scan: expected pixels queued per frame, monitor compares transfers.
module tb_frame_scan;

   localparam int DW   = 24;
   localparam int AW   = 3;
   localparam int LL   = 4;
   localparam int NPIX = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sof;
      logic          eol;
      logic          last;
   } pix_t;

   logic          clk;
   logic          reset;
   logic          frame_rdy;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_ready;
   logic          pix_sof;
   logic          pix_eol;
   logic          busy;
   logic          frame_done;

   logic [DW-1:0] mem [NPIX];
   pix_t          exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            reads = 0;
   int            xfers = 0;
   int            rdy_mode = 0;
   int            rdy_pct = 100;
   logic          done_due = 1'b0;
   logic          held_v = 1'b0;
   logic [DW+1:0] held;

   frame_scan #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .LINE_LEN  (LL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_rdy  (frame_rdy),
      .mem_rd_en  (mem_rd_en),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_sof    (pix_sof),
      .pix_eol    (pix_eol),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      mem_rd_data = '0;
      forever begin
         @(posedge clk);
         if (mem_rd_en == 1'b0) mem_rd_data <= mem[mem_rd_addr];
      end
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: pix_ready = 1'b1;
         1: pix_ready = ~pix_ready;
         2: pix_ready = ($urandom_range(0, 99) < rdy_pct);
         default: pix_ready = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      pix_t e;
      if (!reset) begin
         held_v   = 1'b0;
         done_due = 1'b0;
         reads    = 0;
      end else begin
         if (mem_rd_en == 1'b0) begin
            check("rd_addr", mem_rd_addr, reads % NPIX);
            reads++;
         end
         if (frame_done || done_due) check("frame_done", frame_done, done_due);
         done_due = 1'b0;
         if (held_v) begin
            check("hold_valid", pix_valid, 1);
            check("hold_word", {pix_data, pix_sof, pix_eol}, held);
         end
         held_v = 1'b0;
         if (pix_valid) begin
            check("busy", busy, 1);
            if (pix_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_pixel", pix_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("pix_data", pix_data, e.data);
                  check("pix_sof", pix_sof, e.sof);
                  check("pix_eol", pix_eol, e.eol);
                  xfers++;
                  done_due = e.last;
               end
            end else begin
               held_v = 1'b1;
               held   = {pix_data, pix_sof, pix_eol};
            end
         end
      end
   end

   task automatic fill_mem(input bit ramp);
      for (int k = 0; k < NPIX; k++) mem[k] = ramp ? DW'(k) : DW'($urandom);
   endtask

   // Reference stream for one frame, derived from memory contents and line length
   task automatic push_frame();
      pix_t p;
      for (int k = 0; k < NPIX; k++) begin
         p.data = mem[k];
         p.sof  = (k == 0);
         p.eol  = ((k + 1) % LL) == 0;
         p.last = (k == NPIX - 1);
         exp_q.push_back(p);
      end
   endtask

   task automatic start_frame();
      frame_rdy = 1'b1;
      @(posedge clk);
      #1 frame_rdy = 1'b0;
   endtask

   task automatic wait_frame_done(output int n);
      n = -1;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (frame_done) begin
            n = i;
            break;
         end
      end
      if (n < 0) check("timeout_done", 0, 1);
   endtask

   task automatic finish_frame();
      check("queue_empty", exp_q.size(), 0);
`ifdef FRAME_SCAN_REPEAT_EN
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      check("rst_rd_en", mem_rd_en, 1);
      check("rst_rd_addr", mem_rd_addr, 0);
      check("rst_valid", pix_valid, 0);
      check("rst_sof", pix_sof, 0);
      check("rst_eol", pix_eol, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_data", pix_data, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int n;
      int r0;
      int x0;
      reset     = 1'b0;
      frame_rdy = 1'b0;
      fill_mem(1'b1);
      #12;
      check_reset_outputs();
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Full-rate frame: pixels back to back, done 11 negedges after the start edge
      rdy_mode = 0;
      push_frame();
      start_frame();
      wait_frame_done(n);
      check("latency_full_rate", n, 11);
      finish_frame();

      // Alternating ready
      rdy_mode = 1;
      push_frame();
      start_frame();
      wait_frame_done(n);
      finish_frame();

      // Ready held low: reads stop once two words are buffered or in flight
      fill_mem(1'b0);
      rdy_mode = 3;
      @(posedge clk);
      #1;
      r0 = reads;
      push_frame();
      start_frame();
      repeat (10) @(posedge clk);
      #1;
      check("stall_reads", reads - r0, 2);
      check("stall_valid", pix_valid, 1);
      rdy_mode = 0;
      wait_frame_done(n);
      finish_frame();

      // Reset mid-frame after pixel 3 has transferred
      fill_mem(1'b1);
      rdy_mode = 0;
      x0 = xfers;
      push_frame();
      start_frame();
      for (int i = 0; i < 100 && xfers < x0 + 4; i++) begin
         @(negedge clk);
         #1;
      end
      check("abort_progress", xfers - x0, 4);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_after_abort", {busy, pix_valid}, 2'b00);
      fill_mem(1'b0);
      push_frame();
      start_frame();
      wait_frame_done(n);
      check("restart_latency", n, 11);
      finish_frame();

      // Random data under random back-pressure
      rdy_mode = 2;
      for (int f = 0; f < 4; f++) begin
         fill_mem(1'b0);
         rdy_pct = $urandom_range(20, 100);
         push_frame();
         start_frame();
         wait_frame_done(n);
         finish_frame();
      end

      rdy_mode = 0;
      fill_mem(1'b0);
`ifdef FRAME_SCAN_REPEAT_EN
      // One start pulse, then continuous refresh of the same memory
      push_frame();
      push_frame();
      push_frame();
      start_frame();
      wait_frame_done(n);
      wait_frame_done(n);
      check("refresh_period", n, 11);
      wait_frame_done(n);
      finish_frame();
`else
      // frame_rdy held high across two frames
      push_frame();
      push_frame();
      frame_rdy = 1'b1;
      wait_frame_done(n);
      @(posedge clk);
      #1 frame_rdy = 1'b0;
      wait_frame_done(n);
      check("b2b_latency", n, 11);
      repeat (20) @(posedge clk);
      #1;
      check("idle_after_b2b", {busy, pix_valid}, 2'b00);
      finish_frame();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_scan.md
FRAME_SCAN -- requirements
Module: frame_scan

Interface
REQ-001 Parameter DATA_WIDTH, default 24, pixel word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 3, frame memory address width; frame length is 2^ADDR_WIDTH words.
REQ-003 Parameter LINE_LEN, default 4, pixels per line; 2^ADDR_WIDTH SHALL be an integer multiple of LINE_LEN.
REQ-004 Port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Port frame_rdy, input, 1, active-high: the writer has a complete frame in memory.
REQ-007 Port mem_rd_en, output, 1, memory read enable, active-low (`ASSERT = 0).
REQ-008 Port mem_rd_addr, output, ADDR_WIDTH, memory read address.
REQ-009 Port mem_rd_data, input, DATA_WIDTH, memory read data, valid exactly one clk after mem_rd_en is asserted.
REQ-010 Port pix_data, output, DATA_WIDTH, pixel stream data.
REQ-011 Port pix_valid / pix_ready, output / input, 1 each, active-high stream handshake; a transfer occurs on a clk edge where both are high.
REQ-012 Port pix_sof / pix_eol, output, 1 each, qualified by pix_valid: first pixel of the frame / last pixel of a line.
REQ-013 Port busy, output, 1, high from frame start until the last pixel transfers.
REQ-014 Port frame_done, output, 1, one-cycle pulse on the cycle after the last pixel transfers.

Function
REQ-015 States: IDLE, RUN, DRAIN.
REQ-016 IDLE: frame_rdy high -> RUN; read address counter cleared to 0; busy goes high the same edge.
REQ-017 RUN: issue one read per cycle when the output buffer has at least one free slot counting in-flight reads; address increments by 1 per issued read.
REQ-018 RUN -> DRAIN on the edge that issues the read of address 2^ADDR_WIDTH-1; no address wrap inside a frame.
REQ-019 DRAIN: no reads issued; -> IDLE when the last pixel transfers; frame_done pulses next cycle.
REQ-020 Output buffer: 2-entry skid; pix_valid high whenever an entry is held; data order equals address order; zero bubbles when pix_ready is held high (one pixel per clk after 2-cycle start latency: frame_rdy edge -> first read -> pix_valid).
REQ-021 pix_data, pix_sof and pix_eol SHALL hold stable while pix_valid is high and pix_ready is low.
REQ-022 pix_sof high for address 0 only; pix_eol high for address k where (k+1) mod LINE_LEN = 0; a line counter of width $clog2(LINE_LEN) generates them.
REQ-023 frame_rdy is sampled only in IDLE; changes during RUN/DRAIN are ignored.
REQ-024 pix_ready low for any number of cycles SHALL stall reads without dropping or duplicating pixels.

Reset
REQ-025 Reset low: state IDLE, address 0, line counter 0, buffer empty, mem_rd_en deasserted (1), pix_valid 0, pix_sof 0, pix_eol 0, busy 0, frame_done 0, pix_data 0.
REQ-026 Reset mid-frame aborts immediately; in-flight read data is discarded; after release the block waits in IDLE for frame_rdy.

Configuration
REQ-027 Macro FRAME_SCAN_REPEAT_EN defined: on DRAIN -> IDLE with frame_rdy low, the block re-enters RUN the next edge and rescans the same memory (continuous display refresh); frame_done still pulses per frame.
REQ-028 Macro FRAME_SCAN_REPEAT_EN undefined: the block waits in IDLE until frame_rdy is high.

Structure
REQ-029 Shared package frame_buf_pkg holds `ASSERT/`DEASSERT, the state encoding for IDLE/RUN/DRAIN, and the default width constants.
REQ-030 The 2-entry output buffer SHALL be a sub-module named scan_skid (DATA_WIDTH+2 bits wide, carrying sof/eol).

Verification
REQ-031 ADDR_WIDTH=3, LINE_LEN=4, memory holds 0..7, frame_rdy pulse, pix_ready=1 -> pixels 0..7 on consecutive cycles, sof on 0, eol on 3 and 7, frame_done one cycle after 7.
REQ-032 Same, pix_ready toggling 1,0,1,0 -> sequence 0..7 exact, no duplicates, data stable while stalled.
REQ-033 pix_ready=0 for 10 cycles after start -> at most 2 pixels buffered, exactly 2 reads issued, then 0..7 on release.
REQ-034 Reset asserted after pixel 3 transfers -> all outputs at reset values asynchronously; next frame_rdy restarts at pixel 0 with sof.
REQ-035 frame_rdy held high across two frames, repeat macro undefined -> two back-to-back frames, two frame_done pulses; frame_rdy low with macro defined -> continuous frames.
